// File: rtl/fc8_interrupt_sequencer.sv
// FC8 interrupt sequencer: arbitrates NMI and three latched IRQ sources,
// runs the CPU request/acknowledge/vector handshake and tracks nested handlers.
module fc8_interrupt_sequencer #(
  parameter logic [15:0] VEC_NMI    = 16'hFFFA,
  parameter logic [15:0] VEC_VBLANK = 16'hFFF0,
  parameter logic [15:0] VEC_TIMER  = 16'hFFF2,
  parameter logic [15:0] VEC_EXT    = 16'hFFF4
) (
  input  logic        clk_cpu,
  input  logic        rst,
  input  logic        nmi_in,
  input  logic        vblank_pending,
  input  logic        timer_pending,
  input  logic        external_pending,
  input  logic        cpu_int_mask,
  input  logic        cpu_int_ack,
  input  logic        cpu_reti,
  output logic        int_req,
  output logic        int_is_nmi,
  output logic [15:0] vector_addr,
  output logic        vector_valid,
  output logic        clr_vblank,
  output logic        clr_timer,
  output logic        clr_external,
  output logic [3:0]  in_service,
  output logic [1:0]  nest_depth
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_VEC,
    ST_SVC
  } state_t;

  // Encoding doubles as the bit index into in_service.
  typedef enum logic [1:0] {
    SEL_VBLANK = 2'd0,
    SEL_TIMER  = 2'd1,
    SEL_EXT    = 2'd2,
    SEL_NMI    = 2'd3
  } sel_t;

  state_t      state_q, state_d;
  sel_t        sel_q, sel_d;
  logic        nmi_latch_q, nmi_latch_d;
  logic        nmi_prev_q;
  logic [3:0]  in_service_q, in_service_d;
  logic [1:0]  depth_q, depth_d;

  logic        nmi_edge;
  logic        irq_busy;
  logic        irq_eligible;
  sel_t        irq_top;
  logic        sel_pending;

  assign nmi_edge     = nmi_in & ~nmi_prev_q;
  assign irq_busy     = |in_service_q[2:0];
  assign irq_eligible = (vblank_pending | timer_pending | external_pending)
                        & ~cpu_int_mask & ~irq_busy;

  always_comb begin
    irq_top = SEL_EXT;
    if (vblank_pending) begin
      irq_top = SEL_VBLANK;
    end else if (timer_pending) begin
      irq_top = SEL_TIMER;
    end
  end

  always_comb begin
    sel_pending = 1'b0;
    case (sel_q)
      SEL_VBLANK: sel_pending = vblank_pending;
      SEL_TIMER:  sel_pending = timer_pending;
      SEL_EXT:    sel_pending = external_pending;
      default:    sel_pending = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    nmi_latch_d  = nmi_latch_q;
    in_service_d = in_service_q;
    depth_d      = depth_q;

    case (state_q)
      ST_IDLE: begin
        if (nmi_latch_q) begin
          state_d = ST_REQ;
          sel_d   = SEL_NMI;
        end else if (irq_eligible) begin
          state_d = ST_REQ;
          sel_d   = irq_top;
        end
      end

      ST_REQ: begin
        if (cpu_int_ack) begin
          state_d = ST_VEC;
        end else if (sel_q != SEL_NMI) begin
          if (nmi_latch_q) begin
            sel_d = SEL_NMI;
          end else if (!sel_pending || cpu_int_mask) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_VEC: begin
        state_d             = ST_SVC;
        in_service_d[sel_q] = 1'b1;
        depth_d             = depth_q + 2'd1;
        if (sel_q == SEL_NMI) begin
          nmi_latch_d = 1'b0;
        end
      end

      ST_SVC: begin
        // Return takes precedence over a pending NMI; the NMI is seen next cycle.
        if (cpu_reti) begin
          if (in_service_q[3]) begin
            in_service_d[3] = 1'b0;
          end else begin
            in_service_d[2:0] = '0;
          end
          if (depth_q <= 2'd1) begin
            depth_d      = '0;
            in_service_d = '0;
            state_d      = ST_IDLE;
          end else begin
            depth_d = depth_q - 2'd1;
          end
        end else if (nmi_latch_q && !in_service_q[3]) begin
          state_d = ST_REQ;
          sel_d   = SEL_NMI;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (nmi_edge) begin
      nmi_latch_d = 1'b1;
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= SEL_VBLANK;
      nmi_latch_q  <= 1'b0;
      nmi_prev_q   <= 1'b1;
      in_service_q <= '0;
      depth_q      <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      nmi_latch_q  <= nmi_latch_d;
      nmi_prev_q   <= nmi_in;
      in_service_q <= in_service_d;
      depth_q      <= depth_d;
    end
  end

  always_comb begin
    vector_addr = '0;
    if (state_q == ST_VEC) begin
      case (sel_q)
        SEL_VBLANK: vector_addr = VEC_VBLANK;
        SEL_TIMER:  vector_addr = VEC_TIMER;
        SEL_EXT:    vector_addr = VEC_EXT;
        default:    vector_addr = VEC_NMI;
      endcase
    end
  end

  assign int_req      = (state_q == ST_REQ);
  assign int_is_nmi   = ((state_q == ST_REQ) || (state_q == ST_VEC)) && (sel_q == SEL_NMI);
  assign vector_valid = (state_q == ST_VEC);
  assign clr_vblank   = (state_q == ST_VEC) && (sel_q == SEL_VBLANK);
  assign clr_timer    = (state_q == ST_VEC) && (sel_q == SEL_TIMER);
  assign clr_external = (state_q == ST_VEC) && (sel_q == SEL_EXT);
  assign in_service   = in_service_q;
  assign nest_depth   = depth_q;

endmodule

// File: tb/tb_fc8_interrupt_sequencer.sv
// Bench for fc8_interrupt_sequencer: directed scenarios plus a randomized run
// checked cycle by cycle against a handler-stack reference model.
module tb_fc8_interrupt_sequencer;

  logic        clk_cpu = 1'b0;
  logic        rst = 1'b1;
  logic        nmi_in = 1'b0;
  logic        vblank_pending = 1'b0;
  logic        timer_pending = 1'b0;
  logic        external_pending = 1'b0;
  logic        cpu_int_mask = 1'b0;
  logic        cpu_int_ack = 1'b0;
  logic        cpu_reti = 1'b0;
  logic        int_req;
  logic        int_is_nmi;
  logic [15:0] vector_addr;
  logic        vector_valid;
  logic        clr_vblank;
  logic        clr_timer;
  logic        clr_external;
  logic [3:0]  in_service;
  logic [1:0]  nest_depth;

  int checks = 0;
  int errors = 0;

  fc8_interrupt_sequencer #(
    .VEC_NMI   (16'hFFFA),
    .VEC_VBLANK(16'hFFF0),
    .VEC_TIMER (16'hFFF2),
    .VEC_EXT   (16'hFFF4)
  ) dut (
    .clk_cpu         (clk_cpu),
    .rst             (rst),
    .nmi_in          (nmi_in),
    .vblank_pending  (vblank_pending),
    .timer_pending   (timer_pending),
    .external_pending(external_pending),
    .cpu_int_mask    (cpu_int_mask),
    .cpu_int_ack     (cpu_int_ack),
    .cpu_reti        (cpu_reti),
    .int_req         (int_req),
    .int_is_nmi      (int_is_nmi),
    .vector_addr     (vector_addr),
    .vector_valid    (vector_valid),
    .clr_vblank      (clr_vblank),
    .clr_timer       (clr_timer),
    .clr_external    (clr_external),
    .in_service      (in_service),
    .nest_depth      (nest_depth)
  );

  always #5 clk_cpu = ~clk_cpu;

  // Outputs are sampled 1 time unit after the rising edge; inputs change then too.
  task automatic tick();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; nmi_in = 1'b0; cpu_int_mask = 1'b0; cpu_int_ack = 1'b0; cpu_reti = 1'b0;
    vblank_pending = 1'b0; timer_pending = 1'b0; external_pending = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; timer_pending = 1'b1; cpu_int_ack = 1'b1;
    tick(); tick();
    checks++; if ({int_req, int_is_nmi, vector_valid} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {int_req, int_is_nmi, vector_valid}); end
    checks++; if (vector_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h expected 0000", vector_addr); end
    checks++; if ({clr_vblank, clr_timer, clr_external, in_service, nest_depth} !== 9'b0) begin errors++; $display("FAIL reset_status: got %b expected 0", {clr_vblank, clr_timer, clr_external, in_service, nest_depth}); end
    do_reset();
  endtask

  task automatic test_timer_basic();
    do_reset();
    timer_pending = 1'b1;
    tick();
    checks++; if ({int_req, int_is_nmi} !== 2'b10) begin errors++; $display("FAIL timer_req: got %b expected 10", {int_req, int_is_nmi}); end
    tick(); tick();
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL timer_req_hold: got %b expected 1", int_req); end
    cpu_int_ack = 1'b1;
    tick();
    cpu_int_ack = 1'b0;
    checks++; if ({vector_valid, vector_addr} !== {1'b1, 16'hFFF2}) begin errors++; $display("FAIL timer_vec: got %b/%h expected 1/fff2", vector_valid, vector_addr); end
    checks++; if ({clr_vblank, clr_timer, clr_external} !== 3'b010) begin errors++; $display("FAIL timer_clr: got %b expected 010", {clr_vblank, clr_timer, clr_external}); end
    timer_pending = 1'b0;
    tick();
    checks++; if ({vector_valid, clr_timer, int_req} !== 3'b000) begin errors++; $display("FAIL timer_svc_strobes: got %b expected 000", {vector_valid, clr_timer, int_req}); end
    checks++; if ({in_service, nest_depth} !== {4'b0010, 2'd1}) begin errors++; $display("FAIL timer_svc: got %b/%0d expected 0010/1", in_service, nest_depth); end
    cpu_reti = 1'b1;
    tick();
    cpu_reti = 1'b0;
    checks++; if ({in_service, nest_depth} !== 6'b0) begin errors++; $display("FAIL timer_reti: got %b/%0d expected 0000/0", in_service, nest_depth); end
  endtask

  task automatic test_priority();
    logic [15:0] exp_addr [3];
    logic [2:0]  exp_clr  [3];
    exp_addr[0] = 16'hFFF0; exp_addr[1] = 16'hFFF2; exp_addr[2] = 16'hFFF4;
    exp_clr[0]  = 3'b100;   exp_clr[1]  = 3'b010;   exp_clr[2]  = 3'b001;
    do_reset();
    vblank_pending = 1'b1; timer_pending = 1'b1; external_pending = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL prio_req%0d: got %b expected 1", i, int_req); end
      cpu_int_ack = 1'b1;
      tick();
      cpu_int_ack = 1'b0;
      checks++; if (vector_addr !== exp_addr[i]) begin errors++; $display("FAIL prio_addr%0d: got %h expected %h", i, vector_addr, exp_addr[i]); end
      checks++; if ({clr_vblank, clr_timer, clr_external} !== exp_clr[i]) begin errors++; $display("FAIL prio_clr%0d: got %b expected %b", i, {clr_vblank, clr_timer, clr_external}, exp_clr[i]); end
      if (i == 0) vblank_pending = 1'b0;
      if (i == 1) timer_pending = 1'b0;
      if (i == 2) external_pending = 1'b0;
      tick(); tick(); tick();
      checks++; if ({int_req, nest_depth} !== {1'b0, 2'd1}) begin errors++; $display("FAIL prio_svc%0d: got %b/%0d expected 0/1", i, int_req, nest_depth); end
      cpu_reti = 1'b1;
      tick();
      cpu_reti = 1'b0;
      tick();
    end
    checks++; if ({int_req, nest_depth, in_service} !== 7'b0) begin errors++; $display("FAIL prio_done: got %b/%0d/%b expected 0/0/0000", int_req, nest_depth, in_service); end
  endtask

  task automatic test_nmi_nest();
    do_reset();
    timer_pending = 1'b1;
    tick();
    cpu_int_ack = 1'b1; tick(); cpu_int_ack = 1'b0;
    timer_pending = 1'b0;
    tick();
    nmi_in = 1'b1;
    tick(); tick();
    checks++; if ({int_req, int_is_nmi} !== 2'b11) begin errors++; $display("FAIL nest_req: got %b expected 11", {int_req, int_is_nmi}); end
    cpu_int_ack = 1'b1; tick(); cpu_int_ack = 1'b0;
    checks++; if ({vector_valid, int_is_nmi, vector_addr} !== {2'b11, 16'hFFFA}) begin errors++; $display("FAIL nest_vec: got %b%b/%h expected 11/fffa", vector_valid, int_is_nmi, vector_addr); end
    checks++; if ({clr_vblank, clr_timer, clr_external} !== 3'b000) begin errors++; $display("FAIL nest_noclr: got %b expected 000", {clr_vblank, clr_timer, clr_external}); end
    tick();
    checks++; if ({in_service, nest_depth} !== {4'b1010, 2'd2}) begin errors++; $display("FAIL nest_svc: got %b/%0d expected 1010/2", in_service, nest_depth); end
    nmi_in = 1'b0;
    cpu_reti = 1'b1; tick(); cpu_reti = 1'b0;
    checks++; if ({in_service, nest_depth} !== {4'b0010, 2'd1}) begin errors++; $display("FAIL nest_reti1: got %b/%0d expected 0010/1", in_service, nest_depth); end
    tick();
    cpu_reti = 1'b1; tick(); cpu_reti = 1'b0;
    tick();
    checks++; if ({int_req, in_service, nest_depth} !== 7'b0) begin errors++; $display("FAIL nest_reti2: got %b/%b/%0d expected 0/0000/0", int_req, in_service, nest_depth); end
  endtask

  task automatic test_withdraw();
    do_reset();
    external_pending = 1'b1;
    tick();
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL wd_req: got %b expected 1", int_req); end
    cpu_int_mask = 1'b1;
    tick();
    checks++; if ({int_req, vector_valid, clr_external} !== 3'b000) begin errors++; $display("FAIL wd_drop: got %b expected 000", {int_req, vector_valid, clr_external}); end
    cpu_int_ack = 1'b1;
    tick();
    cpu_int_ack = 1'b0;
    checks++; if ({int_req, vector_valid, clr_external, nest_depth} !== 5'b0) begin errors++; $display("FAIL wd_idle: got %b expected 00000", {int_req, vector_valid, clr_external, nest_depth}); end
    cpu_int_mask = 1'b0; external_pending = 1'b0;
  endtask

  task automatic test_nmi_at_reset();
    do_reset();
    rst = 1'b1; nmi_in = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL nmirst_none: got %b expected 0", int_req); end
    nmi_in = 1'b0; tick();
    nmi_in = 1'b1; tick(); tick();
    checks++; if ({int_req, int_is_nmi} !== 2'b11) begin errors++; $display("FAIL nmirst_edge: got %b expected 11", {int_req, int_is_nmi}); end
    cpu_int_ack = 1'b1; tick(); cpu_int_ack = 1'b0;
    checks++; if (vector_addr !== 16'hFFFA) begin errors++; $display("FAIL nmirst_vec: got %h expected fffa", vector_addr); end
    tick();
    checks++; if ({in_service, nest_depth} !== {4'b1000, 2'd1}) begin errors++; $display("FAIL nmirst_svc: got %b/%0d expected 1000/1", in_service, nest_depth); end
    cpu_reti = 1'b1; tick(); cpu_reti = 1'b0;
    nmi_in = 1'b0;
  endtask

  task automatic test_stray();
    do_reset();
    tick();
    cpu_int_ack = 1'b1; tick(); cpu_int_ack = 1'b0;
    checks++; if ({int_req, vector_valid, vector_addr, in_service, nest_depth} !== 24'b0) begin errors++; $display("FAIL stray_ack: got %b/%b/%h expected zeros", int_req, vector_valid, vector_addr); end
    cpu_reti = 1'b1; tick(); cpu_reti = 1'b0;
    checks++; if ({int_req, vector_valid, in_service, nest_depth} !== 8'b0) begin errors++; $display("FAIL stray_reti: got %b/%b/%b/%0d expected zeros", int_req, vector_valid, in_service, nest_depth); end
  endtask

  // Reference: a stack of active handlers, the source currently being requested,
  // and the source being vectored this cycle (-1 = none). Ids: 0 vblank, 1 timer, 2 ext, 3 NMI.
  task automatic test_random();
    int          m_req = -1;
    int          m_vec = -1;
    int          stk[$];
    bit          m_lat = 1'b0;
    bit          m_prv = 1'b1;
    bit          p[3];
    bit          nmi_act;
    logic [15:0] e_addr;
    logic [3:0]  e_isv;
    logic [2:0]  e_clr;
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk_cpu);
      if (rst) begin
        m_req = -1; m_vec = -1; stk.delete(); m_lat = 1'b0; m_prv = 1'b1;
      end else begin
        p[0] = vblank_pending; p[1] = timer_pending; p[2] = external_pending;
        nmi_act = 1'b0;
        foreach (stk[k]) if (stk[k] == 3) nmi_act = 1'b1;
        if (m_vec >= 0) begin
          stk.push_back(m_vec);
          if (m_vec == 3) m_lat = 1'b0;
          m_vec = -1;
        end else if (m_req >= 0) begin
          if (cpu_int_ack) begin m_vec = m_req; m_req = -1; end
          else if (m_req != 3 && m_lat) m_req = 3;
          else if (m_req != 3 && (!p[m_req] || cpu_int_mask)) m_req = -1;
        end else if (stk.size() > 0) begin
          if (cpu_reti) stk.delete(stk.size() - 1);
          else if (m_lat && !nmi_act) m_req = 3;
        end else if (m_lat) begin
          m_req = 3;
        end else if (!cpu_int_mask) begin
          for (int s = 2; s >= 0; s--) if (p[s]) m_req = s;
        end
        if (nmi_in && !m_prv) m_lat = 1'b1;
        m_prv = nmi_in;
      end
      #1;
      case (m_vec)
        0: e_addr = 16'hFFF0;
        1: e_addr = 16'hFFF2;
        2: e_addr = 16'hFFF4;
        3: e_addr = 16'hFFFA;
        default: e_addr = 16'h0000;
      endcase
      e_isv = 4'b0;
      foreach (stk[k]) e_isv[stk[k]] = 1'b1;
      e_clr = {m_vec == 0, m_vec == 1, m_vec == 2};
      checks++; if (int_req !== (m_req >= 0)) begin errors++; $display("FAIL rnd_int_req cyc %0d: got %b expected %b", cyc, int_req, m_req >= 0); end
      checks++; if (int_is_nmi !== (m_req == 3 || m_vec == 3)) begin errors++; $display("FAIL rnd_is_nmi cyc %0d: got %b expected %b", cyc, int_is_nmi, m_req == 3 || m_vec == 3); end
      checks++; if ({vector_valid, vector_addr} !== {m_vec >= 0, e_addr}) begin errors++; $display("FAIL rnd_vector cyc %0d: got %b/%h expected %b/%h", cyc, vector_valid, vector_addr, m_vec >= 0, e_addr); end
      checks++; if ({clr_vblank, clr_timer, clr_external} !== e_clr) begin errors++; $display("FAIL rnd_clr cyc %0d: got %b expected %b", cyc, {clr_vblank, clr_timer, clr_external}, e_clr); end
      checks++; if ({in_service, nest_depth} !== {e_isv, 2'(stk.size())}) begin errors++; $display("FAIL rnd_service cyc %0d: got %b/%0d expected %b/%0d", cyc, in_service, nest_depth, e_isv, stk.size()); end
      // Status sources clear at the end of their vector cycle, like the real latches.
      if (m_vec == 0) vblank_pending = 1'b0;
      if (m_vec == 1) timer_pending = 1'b0;
      if (m_vec == 2) external_pending = 1'b0;
      if ($urandom_range(0, 7) == 0) vblank_pending = 1'b1;
      if ($urandom_range(0, 7) == 0) timer_pending = 1'b1;
      if ($urandom_range(0, 7) == 0) external_pending = 1'b1;
      if ($urandom_range(0, 39) == 0) timer_pending = 1'b0;
      if ($urandom_range(0, 39) == 0) external_pending = 1'b0;
      if ($urandom_range(0, 9) == 0) cpu_int_mask = ~cpu_int_mask;
      if ($urandom_range(0, 11) == 0) nmi_in = ~nmi_in;
      cpu_int_ack = ($urandom_range(0, 2) == 0);
      cpu_reti    = ($urandom_range(0, 4) == 0);
      rst         = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0; cpu_int_ack = 1'b0; cpu_reti = 1'b0;
  endtask

  initial begin
    test_reset();
    test_timer_basic();
    test_priority();
    test_nmi_nest();
    test_withdraw();
    test_nmi_at_reset();
    test_stray();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc8_interrupt_sequencer.md
FC8_INTERRUPT_SEQUENCER -- requirements
Module: fc8_interrupt_sequencer

Interface
REQ-001 Parameter VEC_NMI, 16'hFFFA, NMI handler vector.
REQ-002 Parameter VEC_VBLANK, 16'hFFF0, VBLANK IRQ vector.
REQ-003 Parameter VEC_TIMER, 16'hFFF2, timer IRQ vector.
REQ-004 Parameter VEC_EXT, 16'hFFF4, external IRQ vector.
REQ-005 Port clk_cpu  input  1  sole clock; all logic on rising edge.
REQ-006 Port rst  input  1  reset, synchronous, active-high.
REQ-007 Port nmi_in  input  1  NMI request level from interrupt controller.
REQ-008 Port vblank_pending / timer_pending / external_pending  input  1 each  latched status bits.
REQ-009 Port cpu_int_mask  input  1  CPU I flag; 1 masks IRQs (not NMI).
REQ-010 Port cpu_int_ack  input  1  single-cycle CPU acceptance of int_req.
REQ-011 Port cpu_reti  input  1  single-cycle return-from-interrupt.
REQ-012 Port int_req  output  1  interrupt request to CPU.
REQ-013 Port int_is_nmi  output  1  current request/vector is NMI.
REQ-014 Port vector_addr  output  16  handler address, valid with vector_valid, else 16'h0000.
REQ-015 Port vector_valid  output  1  single-cycle vector strobe.
REQ-016 Port clr_vblank / clr_timer / clr_external  output  1 each  single-cycle status-clear pulses.
REQ-017 Port in_service  output  4  {nmi, ext, timer, vblank} in-service bits.
REQ-018 Port nest_depth  output  2  active handler count, 0..2.

Function
REQ-019 NMI edge: rising edge = nmi_in=1 with registered previous 0; sets nmi_latch; edges while nmi_latch=1 coalesce.
REQ-020 nmi_latch clears only in VEC with NMI selected; an edge in that same cycle re-sets it.
REQ-021 IRQ eligible = any pending & !cpu_int_mask & no IRQ in_service bit set.
REQ-022 Fixed priority NMI > vblank > timer > external; selection captured in sel register.
REQ-023 States IDLE, REQ, VEC, SVC.
REQ-024 IDLE: nmi_latch -> REQ, sel=NMI; else eligible IRQ -> REQ, sel=highest pending; else stay.
REQ-025 REQ: int_req=1, int_is_nmi=(sel==NMI); cpu_int_ack -> VEC.
REQ-026 REQ, IRQ sel, no ack: nmi_latch set -> stay REQ, sel=NMI (upgrade).
REQ-027 REQ, IRQ sel, no ack: selected pending drops or mask rises -> withdraw to IDLE; int_req low next cycle.
REQ-028 Ack same cycle as upgrade/withdraw condition: ack wins, current sel vectored.
REQ-029 VEC (one cycle): vector_valid=1, vector_addr=sel vector, clr_<sel> pulse if IRQ, in_service[sel] set, nest_depth+1; -> SVC.
REQ-030 Latency: pending seen in IDLE cycle N -> int_req at N+1; ack at M -> vector_valid/clear at M+1, SVC at M+2.
REQ-031 SVC: nmi_latch=1 and NMI not in service -> REQ sel=NMI (one nesting level).
REQ-032 SVC: NMI in service, new NMI latched -> held until reti.
REQ-033 SVC cpu_reti: clear most recent in_service bit (NMI before IRQ), nest_depth-1; 0 -> IDLE, else stay SVC.
REQ-034 SVC reti and preempt NMI same cycle: reti processed first; re-evaluated next cycle.
REQ-035 cpu_int_ack outside REQ, cpu_reti outside SVC: ignored.
REQ-036 IRQs never vectored in SVC; nest_depth never exceeds 2.

Reset
REQ-037 rst=1: state IDLE, sel cleared, nmi_latch=0, NMI-previous register=1 (nmi_in high at release is not an edge), all outputs 0.
REQ-038 rst mid-operation: abandons handshake; same values next cycle; pending inputs re-arbitrated after release.

Verification
REQ-039 timer_pending=1, mask=0; ack two cycles after int_req -> vector_addr=16'hFFF2, clr_timer one cycle, in_service=4'b0010, depth=1.
REQ-040 vblank+timer+external pending same cycle -> VBLANK vectored (16'hFFF0); after reti timer, then external.
REQ-041 Timer in service, nmi_in 0->1 -> int_req, int_is_nmi=1, vector 16'hFFFA, in_service=4'b1010, depth=2; reti -> 4'b0010; reti -> IDLE.
REQ-042 external_pending in REQ, mask rises before ack -> int_req low next cycle, no clear pulse, state IDLE.
REQ-043 nmi_in high during and after rst -> no NMI; later 0->1 -> NMI.
REQ-044 Stray cpu_int_ack in IDLE, cpu_reti in IDLE -> no output change.
